// File: rtl/servo_pkg.sv
// servo_pkg: shared FSM state, command record, default limits and the range clamp
package servo_pkg;
  typedef enum logic {IDLE, RAMP} state_t;
  typedef struct packed {
    logic [15:0] target;
    logic [7:0]  step;
  } cmd_t;
  localparam int MIN_US_D    = 1000;
  localparam int MAX_US_D    = 2000;
  localparam int CENTER_US_D = 1500;
  localparam int FRAME_US_D  = 20000;
  function automatic logic [15:0] clamp(input logic [15:0] v, input logic [15:0] lo, input logic [15:0] hi);
    return v < lo ? lo : (v > hi ? hi : v);
  endfunction
endpackage

// File: rtl/servo_cmd_fifo.sv
// servo_cmd_fifo: 2-deep command queue (clk, rst, i_push/i_din in, i_pop, o_head/o_full/o_empty out)
module servo_cmd_fifo
  import servo_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic i_push,
  input  logic i_pop,
  input  cmd_t i_din,
  output cmd_t o_head,
  output logic o_full,
  output logic o_empty
);
  cmd_t       r_mem [2];
  logic [1:0] r_cnt;
  logic       r_wp, r_rp;
  logic       w_push, w_pop;
  assign o_full  = r_cnt == 2'd2;
  assign o_empty = r_cnt == 2'd0;
  assign o_head  = r_mem[r_rp];
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
      r_wp  <= 1'b0;
      r_rp  <= 1'b0;
    end else begin
      if (w_push) begin
        r_mem[r_wp] <= i_din;
        r_wp        <= ~r_wp;
      end
      if (w_pop) r_rp <= ~r_rp;
      r_cnt <= r_cnt + 2'(w_push) - 2'(w_pop);
    end
  end
endmodule

// File: rtl/servo_ramp_ctrl.sv
// servo_ramp_ctrl: queued, slew-limited servo pulse_len sequencer (cmd_valid/ready/target/step in, pulse_len/frame_tick/busy/at_target out)
module servo_ramp_ctrl
  import servo_pkg::*;
#(
  parameter int CLK_F     = 50,
  parameter int FRAME_US  = FRAME_US_D,
  parameter int MIN_US    = MIN_US_D,
  parameter int MAX_US    = MAX_US_D,
  parameter int CENTER_US = CENTER_US_D
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [15:0] cmd_target,
  input  logic [7:0]  cmd_step,
  output logic [15:0] pulse_len,
  output logic        frame_tick,
  output logic        busy,
  output logic        at_target
);
  logic [15:0] r_pre, r_us, r_pulse, r_tgt, w_pulse_nx, w_tgt_nx, w_step16;
  logic [7:0]  r_step, w_step_nx;
  logic [16:0] w_diff;
  state_t      r_state, w_state_nx;
  cmd_t        w_din, w_head;
  logic        w_us_tick, w_full, w_empty, w_pop, w_up, w_done;
  assign w_us_tick  = r_pre == 16'(CLK_F - 1);
  assign frame_tick = w_us_tick && r_us == 16'(FRAME_US - 1);
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_pre <= '0;
      r_us  <= '0;
    end else begin
      r_pre <= w_us_tick ? '0 : r_pre + 16'd1;
      if (w_us_tick) r_us <= r_us == 16'(FRAME_US - 1) ? '0 : r_us + 16'd1;
    end
  end
  assign cmd_ready = !w_full && !RST;
  assign w_din     = '{target: clamp(cmd_target, 16'(MIN_US), 16'(MAX_US)), step: cmd_step};
  assign w_pop     = r_state == IDLE && !w_empty;
  servo_cmd_fifo u_fifo (
    .clk    (CLK),
    .rst    (RST),
    .i_push (cmd_valid && cmd_ready),
    .i_pop  (w_pop),
    .i_din  (w_din),
    .o_head (w_head),
    .o_full (w_full),
    .o_empty(w_empty)
  );
  assign w_up     = r_tgt > r_pulse;
  assign w_diff   = w_up ? {1'b0, r_tgt} - {1'b0, r_pulse} : {1'b0, r_pulse} - {1'b0, r_tgt};
  assign w_done   = r_step == 8'd0 || w_diff <= 17'(r_step);
  assign w_step16 = {8'd0, r_step};
  always_comb begin
    w_state_nx = r_state;
    w_tgt_nx   = r_tgt;
    w_step_nx  = r_step;
    w_pulse_nx = r_pulse;
    if (r_state == IDLE) begin
      if (!w_empty) begin
        w_state_nx = RAMP;
        w_tgt_nx   = w_head.target;
        w_step_nx  = w_head.step;
      end
    end else if (frame_tick) begin
      w_pulse_nx = w_done ? r_tgt : (w_up ? r_pulse + w_step16 : r_pulse - w_step16);
      w_state_nx = w_done ? IDLE : RAMP;
    end
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= IDLE;
      r_pulse <= 16'(CENTER_US);
      r_tgt   <= 16'(CENTER_US);
      r_step  <= '0;
    end else begin
      r_state <= w_state_nx;
      r_pulse <= w_pulse_nx;
      r_tgt   <= w_tgt_nx;
      r_step  <= w_step_nx;
    end
  end
  assign pulse_len = r_pulse;
  assign busy      = r_state == RAMP || !w_empty;
  assign at_target = r_state == IDLE && w_empty;
endmodule

// File: tb/tb_servo_ramp_ctrl.sv
// tb_servo_ramp_ctrl: directed vector table plus hand sequences for reset, back-pressure and mid-ramp reset
module tb_servo_ramp_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [15:0] cmd_target = '0;
  logic [7:0]  cmd_step = '0;
  logic [15:0] pulse_len;
  logic        frame_tick, busy, at_target;
  int          n_checks = 0;
  int          n_err = 0;
  typedef struct packed {
    logic [15:0]      tgt;
    logic [7:0]       step;
    logic [2:0]       n;
    logic [3:0][15:0] exp;
  } vec_t;
  vec_t vecs [6];
  always #5 clk = ~clk;
  servo_ramp_ctrl #(.CLK_F(2), .FRAME_US(20)) dut (
    .CLK       (clk),
    .RST       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_target(cmd_target),
    .cmd_step  (cmd_step),
    .pulse_len (pulse_len),
    .frame_tick(frame_tick),
    .busy      (busy),
    .at_target (at_target)
  );
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask
  task automatic push(input logic [15:0] t, input logic [7:0] s);
    bit ok = 0;
    @(negedge clk);
    cmd_valid  = 1'b1;
    cmd_target = t;
    cmd_step   = s;
    for (int i = 0; i < 200; i++) begin
      if (cmd_ready) begin
        @(posedge clk);
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    #1 cmd_valid = 1'b0;
    check("push_accepted", 32'(ok), 1);
  endtask
  task automatic push_go(input logic [15:0] t, input logic [7:0] s);
    push(t, s);
    @(posedge clk);
    #1;
  endtask
  task automatic wait_tick();
    logic [15:0] p0 = pulse_len;
    bit moved = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (frame_tick) break;
      if (pulse_len !== p0) moved = 1;
    end
    check("tick_seen", 32'(frame_tick), 1);
    check("hold_between_ticks", 32'(moved), 0);
    @(posedge clk);
    #1;
  endtask
  initial begin
    bit third_done;
    bit moved;
    int n;
    vecs[0] = '{16'd1540, 8'd10, 3'd4, {16'd1540, 16'd1530, 16'd1520, 16'd1510}};
    vecs[1] = '{16'd1500, 8'd0,  3'd1, {16'd0, 16'd0, 16'd0, 16'd1500}};
    vecs[2] = '{16'd1475, 8'd10, 3'd3, {16'd0, 16'd1475, 16'd1480, 16'd1490}};
    vecs[3] = '{16'd2500, 8'd0,  3'd1, {16'd0, 16'd0, 16'd0, 16'd2000}};
    vecs[4] = '{16'd100,  8'd0,  3'd1, {16'd0, 16'd0, 16'd0, 16'd1000}};
    vecs[5] = '{16'd1000, 8'd0,  3'd1, {16'd0, 16'd0, 16'd0, 16'd1000}};
    repeat (3) @(posedge clk);
    #1;
    check("rst_pulse_len", 32'(pulse_len), 1500);
    check("rst_at_target", 32'(at_target), 1);
    check("rst_busy", 32'(busy), 0);
    check("rst_cmd_ready", 32'(cmd_ready), 0);
    check("rst_frame_tick", 32'(frame_tick), 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_rst_cmd_ready", 32'(cmd_ready), 1);
    n = 0;
    while (!frame_tick && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("first_tick_cycle", 32'(n + 1), 40);
    @(posedge clk);
    #1;
    check("idle_tick_no_move", 32'(pulse_len), 1500);
    for (int v = 0; v < 6; v++) begin
      push_go(vecs[v].tgt, vecs[v].step);
      check("ramp_busy", 32'(busy), 1);
      check("ramp_not_at_target", 32'(at_target), 0);
      for (int j = 0; j < int'(vecs[v].n); j++) begin
        wait_tick();
        check("ramp_pulse_len", 32'(pulse_len), 32'(vecs[v].exp[j]));
      end
      check("done_at_target", 32'(at_target), 1);
      check("done_busy", 32'(busy), 0);
    end
    push_go(16'd1100, 8'd50);
    push(16'd1200, 8'd0);
    push(16'd1300, 8'd0);
    check("full_cmd_ready", 32'(cmd_ready), 0);
    third_done = 0;
    fork
      begin
        push(16'd1400, 8'd0);
        third_done = 1;
      end
      begin
        wait_tick();
        check("q_ramp_1", 32'(pulse_len), 1050);
        check("backpressure_held", 32'(third_done), 0);
        check("backpressure_ready", 32'(cmd_ready), 0);
        wait_tick();
        check("q_ramp_2", 32'(pulse_len), 1100);
      end
    join
    wait_tick();
    check("q_order_a", 32'(pulse_len), 1200);
    wait_tick();
    check("q_order_b", 32'(pulse_len), 1300);
    wait_tick();
    check("q_order_c", 32'(pulse_len), 1400);
    check("q_done_at_target", 32'(at_target), 1);
    push_go(16'd1900, 8'd5);
    wait_tick();
    check("rr_first_step", 32'(pulse_len), 1405);
    push(16'd1950, 8'd0);
    check("rr_busy", 32'(busy), 1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rr_pulse_len", 32'(pulse_len), 1500);
    check("rr_busy_cleared", 32'(busy), 0);
    check("rr_at_target", 32'(at_target), 1);
    check("rr_cmd_ready_in_rst", 32'(cmd_ready), 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rr_cmd_ready_after", 32'(cmd_ready), 1);
    moved = 0;
    repeat (100) begin
      @(negedge clk);
      if (pulse_len !== 16'd1500 || busy !== 1'b0) moved = 1;
    end
    check("rr_no_motion", 32'(moved), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
